// File: rtl/router_pkt_framer.sv
// router_pkt_framer: collects one packet's payload into a local buffer, then
// streams header, payload and XOR parity to the router without gaps while
// honouring router busy, and reports the router's parity verdict per packet.
module router_pkt_framer #(
  parameter int MAX_LEN = 63,  // buffer depth, at most 63 to fit the header
  parameter int CHK_WIN = 3    // cycles of router error sampling after parity
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic [1:0]  req_addr,
  input  logic [5:0]  req_len,
  output logic        req_ready,
  input  logic        pl_valid,
  input  logic [7:0]  pl_data,
  output logic        pl_ready,
  input  logic        busy,
  input  logic        error,
  output logic        pkt_valid,
  output logic [7:0]  din,
  output logic        tx_done,
  output logic        tx_err,
  output logic        cfg_err,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
);

  localparam int               WIN_W     = (CHK_WIN > 1) ? $clog2(CHK_WIN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(CHK_WIN - 1);
  localparam logic [5:0]       MAX_LEN_L = 6'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,   // waiting for a request
    S_FILL,   // buffering payload bytes
    S_HDR,    // header on din
    S_PL,     // payload byte idx on din
    S_PAR,    // parity byte on din
    S_CHECK   // sampling router error
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        addr_q, addr_d;
  logic [5:0]        len_q, len_d;
  logic [5:0]        idx_q, idx_d;
  logic [7:0]        par_q, par_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              lat_q, lat_d;
  logic              req_ready_q, req_ready_d;
  logic              pl_ready_q, pl_ready_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic [7:0]        din_q, din_d;
  logic              tx_done_q, tx_done_d;
  logic              tx_err_q, tx_err_d;
  logic              cfg_err_q, cfg_err_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [7:0]        mem_q [MAX_LEN];

  logic req_fire, req_bad, pl_fire, pl_last, win_last, err_seen;

  assign req_fire = req_valid & req_ready_q & (state_q == S_IDLE);
  assign req_bad  = (req_len == 6'd0) | (req_addr == 2'd3) | (req_len > MAX_LEN_L);
  assign pl_fire  = pl_valid & pl_ready_q & (state_q == S_FILL);
  assign pl_last  = (idx_q == len_q - 6'd1);
  assign win_last = (win_q == WIN_LAST);
  assign err_seen = lat_q | error;

  // Next-state selection; every transmit step waits for the router to be idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (req_fire && !req_bad) state_d = S_FILL;
      S_FILL:  if (pl_fire && pl_last)   state_d = S_HDR;
      S_HDR:   if (!busy)                state_d = S_PL;
      S_PL:    if (!busy && pl_last)     state_d = S_PAR;
      S_PAR:   if (!busy)                state_d = S_CHECK;
      S_CHECK: if (win_last)             state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values for the current state.
  always_comb begin
    // NOTE: every _d starts from its _q (or pulse default) so no path infers a latch.
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    par_d       = par_q;
    win_d       = win_q;
    lat_d       = lat_q;
    pkt_valid_d = pkt_valid_q;
    din_d       = din_q;
    pkt_cnt_d   = pkt_cnt_q;
    err_cnt_d   = err_cnt_q;
    tx_done_d   = 1'b0;
    tx_err_d    = 1'b0;
    cfg_err_d   = 1'b0;
    req_ready_d = (state_d == S_IDLE);
    pl_ready_d  = (state_d == S_FILL);

    unique case (state_q)
      S_IDLE: begin
        lat_d = 1'b0;
        if (req_fire) begin
          if (req_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            addr_d = req_addr;
            len_d  = req_len;
            par_d  = {req_len, req_addr};
            idx_d  = 6'd0;
          end
        end
      end
      S_FILL: begin
        if (pl_fire) begin
          par_d = par_q ^ pl_data;
          idx_d = idx_q + 6'd1;
          if (pl_last) begin
            pkt_valid_d = 1'b1;
            din_d       = {len_q, addr_q};
          end
        end
      end
      S_HDR: begin
        if (!busy) begin
          din_d = mem_q[0];
          idx_d = 6'd0;
        end
      end
      S_PL: begin
        if (!busy) begin
          if (!pl_last) begin
            idx_d = idx_q + 6'd1;
            din_d = mem_q[idx_q + 6'd1];
          end else begin
            pkt_valid_d = 1'b0;
            din_d       = par_q;
          end
        end
      end
      S_PAR: begin
        if (!busy) begin
          din_d = 8'd0;
          win_d = '0;
        end
      end
      S_CHECK: begin
        win_d = win_q + 1'b1;
        if (error) lat_d = 1'b1;
        if (win_last) begin
          tx_done_d = 1'b1;
          tx_err_d  = err_seen;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          if (err_seen) err_cnt_d = err_cnt_q + 16'd1;
          lat_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rstn) begin
      state_q     <= S_IDLE;
      addr_q      <= 2'd0;
      len_q       <= 6'd0;
      idx_q       <= 6'd0;
      par_q       <= 8'd0;
      win_q       <= '0;
      lat_q       <= 1'b0;
      req_ready_q <= 1'b0;
      pl_ready_q  <= 1'b0;
      pkt_valid_q <= 1'b0;
      din_q       <= 8'd0;
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      pkt_cnt_q   <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      par_q       <= par_d;
      win_q       <= win_d;
      lat_q       <= lat_d;
      req_ready_q <= req_ready_d;
      pl_ready_q  <= pl_ready_d;
      pkt_valid_q <= pkt_valid_d;
      din_q       <= din_d;
      tx_done_q   <= tx_done_d;
      tx_err_q    <= tx_err_d;
      cfg_err_q   <= cfg_err_d;
      pkt_cnt_q   <= pkt_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Payload buffer write on each accepted payload beat.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is never read before being written, so it carries no reset.
    if (pl_fire) mem_q[idx_q] <= pl_data;
  end

  assign req_ready = req_ready_q;
  assign pl_ready  = pl_ready_q;
  assign pkt_valid = pkt_valid_q;
  assign din       = din_q;
  assign tx_done   = tx_done_q;
  assign tx_err    = tx_err_q;
  assign cfg_err   = cfg_err_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_router_pkt_framer.sv
// tb_router_pkt_framer: drives requests, payload, router busy and error, and
// compares the consumed byte stream and per-packet reports against a model
// built directly from the packet format (header, payload, XOR parity).
module tb_router_pkt_framer;

  localparam int CHK_WIN = 3;

  typedef logic [7:0] byte_q_t [$];

  logic        clk, rstn;
  logic        req_valid, pl_valid, busy, error;
  logic [1:0]  req_addr;
  logic [5:0]  req_len;
  logic [7:0]  pl_data;
  logic        req_ready, pl_ready, pkt_valid, tx_done, tx_err, cfg_err;
  logic [7:0]  din;
  logic [15:0] pkt_cnt, err_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_pkt_cnt = 16'd0;
  logic [15:0] exp_err_cnt = 16'd0;

  router_pkt_framer #(.MAX_LEN(63), .CHK_WIN(CHK_WIN)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
    .busy(busy), .error(error),
    .pkt_valid(pkt_valid), .din(din),
    .tx_done(tx_done), .tx_err(tx_err), .cfg_err(cfg_err),
    .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic byte_q_t rand_payload(input int n);
    byte_q_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
    return q;
  endfunction

  // Full packet: request, fill, transmit, check window; compares against the model.
  task automatic send_packet(input string tag, input logic [1:0] addr, input int len,
                             input byte_q_t pl, input int gap_pct, input int busy_pct,
                             input int stall_idx, input int stall_len, input int err_cyc,
                             input bit noise);
    logic [7:0] exp_d[$];
    logic       exp_v[$];
    logic [7:0] got_d[$];
    logic       got_v[$];
    logic [7:0] hdr, par, prev_din;
    logic       prev_v, prev_busy, rdy, b, exp_err, saw_cfg;
    int         beats, cyc, stall_left;

    hdr = 8'(len * 4 + int'(addr));
    par = hdr;
    exp_d.push_back(hdr);
    exp_v.push_back(1'b1);
    for (int i = 0; i < len; i++) begin
      exp_d.push_back(pl[i]);
      exp_v.push_back(1'b1);
      par = par ^ pl[i];
    end
    exp_d.push_back(par);
    exp_v.push_back(1'b0);

    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s req_ready: got %b want 1", tag, req_ready);
      return;
    end
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = 6'(len);
    @(negedge clk);
    req_valid = 1'b0;

    beats = 0;
    cyc   = 0;
    while (beats < len && cyc < 2000) begin
      rdy      = pl_ready;
      pl_valid = ($urandom_range(99) >= gap_pct);
      pl_data  = pl[beats];
      @(negedge clk);
      if (pl_valid && rdy) beats++;
      cyc++;
    end
    pl_valid = 1'b0;
    checks++;
    if (beats != len) begin
      errors++;
      $display("FAIL %s fill timeout: got %0d beats want %0d", tag, beats, len);
      return;
    end

    checks++;
    if (din !== hdr || pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s header latency: din=%h pkt_valid=%b want %h/1", tag, din, pkt_valid, hdr);
    end

    cyc        = 0;
    prev_busy  = 1'b0;
    prev_din   = 8'd0;
    prev_v     = 1'b0;
    stall_left = stall_len;
    saw_cfg    = 1'b0;
    while (got_d.size() < len + 2 && cyc < 4000) begin
      if (prev_busy) begin
        checks++;
        if (din !== prev_din || pkt_valid !== prev_v) begin
          errors++;
          $display("FAIL %s busy hold: din=%h pkt_valid=%b want %h/%b", tag, din, pkt_valid,
                   prev_din, prev_v);
        end
      end
      if (cfg_err !== 1'b0) saw_cfg = 1'b1;
      if (got_d.size() == stall_idx && stall_left > 0) begin
        b = 1'b1;
        stall_left--;
      end else begin
        b = ($urandom_range(99) < busy_pct);
      end
      busy = b;
      if (noise) begin
        req_valid = 1'($urandom_range(1));
        req_addr  = 2'd3;
        req_len   = 6'd0;
        pl_valid  = 1'($urandom_range(1));
        pl_data   = 8'($urandom_range(255));
        error     = 1'($urandom_range(1));
      end
      if (!b) begin
        got_d.push_back(din);
        got_v.push_back(pkt_valid);
      end
      prev_busy = b;
      prev_din  = din;
      prev_v    = pkt_valid;
      @(negedge clk);
      cyc++;
    end
    busy      = 1'b0;
    req_valid = 1'b0;
    pl_valid  = 1'b0;
    error     = 1'b0;

    checks++;
    if (got_d.size() != len + 2 || saw_cfg) begin
      errors++;
      $display("FAIL %s transmit: got %0d bytes cfg_err_seen=%b want %0d/0", tag,
               got_d.size(), saw_cfg, len + 2);
      return;
    end
    for (int i = 0; i < len + 2; i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_v[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL %s byte %0d: din=%h pkt_valid=%b want %h/%b", tag, i, got_d[i],
                 got_v[i], exp_d[i], exp_v[i]);
      end
    end

    exp_err = 1'b0;
    for (int c = 1; c <= CHK_WIN; c++) begin
      error = (c == err_cyc);
      if (c == err_cyc) exp_err = 1'b1;
      @(negedge clk);
      error = 1'b0;
      if (c == 1) begin
        checks++;
        if (din !== 8'd0 || pkt_valid !== 1'b0) begin
          errors++;
          $display("FAIL %s check idle: din=%h pkt_valid=%b want 00/0", tag, din, pkt_valid);
        end
      end
      if (c < CHK_WIN) begin
        checks++;
        if (tx_done !== 1'b0) begin
          errors++;
          $display("FAIL %s early tx_done: got %b want 0 at window cycle %0d", tag, tx_done, c);
        end
      end
    end
    exp_pkt_cnt = exp_pkt_cnt + 16'd1;
    if (exp_err) exp_err_cnt = exp_err_cnt + 16'd1;
    checks++;
    if (tx_done !== 1'b1 || tx_err !== exp_err) begin
      errors++;
      $display("FAIL %s tx report: tx_done=%b tx_err=%b want 1/%b", tag, tx_done, tx_err, exp_err);
    end
    checks++;
    if (pkt_cnt !== exp_pkt_cnt || err_cnt !== exp_err_cnt) begin
      errors++;
      $display("FAIL %s counters: pkt_cnt=%0d err_cnt=%0d want %0d/%0d", tag, pkt_cnt, err_cnt,
               exp_pkt_cnt, exp_err_cnt);
    end
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0) begin
      errors++;
      $display("FAIL %s tx_done pulse: got %b want 0", tag, tx_done);
    end
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    req_valid = 1'b0;
    req_addr  = 2'd0;
    req_len   = 6'd0;
    pl_valid  = 1'b0;
    pl_data   = 8'd0;
    busy      = 1'b0;
    error     = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, pl_ready, pkt_valid, tx_done, tx_err, cfg_err} !== 6'b0 || din !== 8'd0) begin
      errors++;
      $display("FAIL reset flags: rdy/plrdy/pv/done/err/cfg=%b din=%h want 000000/00",
               {req_ready, pl_ready, pkt_valid, tx_done, tx_err, cfg_err}, din);
    end
    checks++;
    if (pkt_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset counters: pkt_cnt=%0d err_cnt=%0d want 0/0", pkt_cnt, err_cnt);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || pl_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset idle: req_ready=%b pl_ready=%b want 1/0", req_ready, pl_ready);
    end
  endtask

  task automatic test_basic();
    byte_q_t pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_packet("basic", 2'd1, 4, pl, 0, 0, -1, 0, 0, 1'b0);
  endtask

  task automatic test_busy_stall();
    byte_q_t pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_packet("stall", 2'd1, 4, pl, 0, 0, 2, 3, 0, 1'b0);
  endtask

  task automatic test_router_error();
    byte_q_t pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_packet("rerr", 2'd1, 4, pl, 0, 0, -1, 0, 2, 1'b0);
    send_packet("rerr_next", 2'd0, 3, rand_payload(3), 0, 0, -1, 0, 0, 1'b0);
  endtask

  task automatic test_reject();
    pl_valid = 1'b1;
    pl_data  = 8'hA5;
    req_valid = 1'b1;
    req_addr  = 2'd3;
    req_len   = 6'd5;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (cfg_err !== 1'b1 || req_ready !== 1'b1 || pl_ready !== 1'b0 || pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reject addr3: cfg_err=%b req_ready=%b pl_ready=%b pkt_valid=%b want 1/1/0/0",
               cfg_err, req_ready, pl_ready, pkt_valid);
    end
    @(negedge clk);
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reject pulse: cfg_err=%b want 0", cfg_err);
    end
    req_valid = 1'b1;
    req_addr  = 2'd0;
    req_len   = 6'd0;
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (cfg_err !== 1'b1 || req_ready !== 1'b1 || pl_ready !== 1'b0) begin
      errors++;
      $display("FAIL reject len0: cfg_err=%b req_ready=%b pl_ready=%b want 1/1/0",
               cfg_err, req_ready, pl_ready);
    end
    @(negedge clk);
    pl_valid = 1'b0;
    checks++;
    if (cfg_err !== 1'b0 || pkt_valid !== 1'b0 || pkt_cnt !== exp_pkt_cnt ||
        err_cnt !== exp_err_cnt) begin
      errors++;
      $display("FAIL reject after: cfg_err=%b pkt_valid=%b pkt_cnt=%0d err_cnt=%0d want 0/0/%0d/%0d",
               cfg_err, pkt_valid, pkt_cnt, err_cnt, exp_pkt_cnt, exp_err_cnt);
    end
  endtask

  task automatic test_max_len();
    send_packet("maxlen", 2'd2, 63, rand_payload(63), 40, 0, -1, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    int len;
    for (int n = 0; n < 6; n++) begin
      len = $urandom_range(20, 1);
      send_packet($sformatf("rand%0d", n), 2'($urandom_range(2)), len, rand_payload(len),
                  30, 30, -1, 0, $urandom_range(CHK_WIN), 1'b1);
    end
  endtask

  task automatic test_reset_mid_send();
    byte_q_t pl = rand_payload(8);
    int cyc = 0;
    while (req_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b1;
    req_addr  = 2'd0;
    req_len   = 6'd8;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pl_valid = 1'b1;
      pl_data  = pl[i];
      @(negedge clk);
    end
    pl_valid = 1'b0;
    busy     = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (din !== pl[5] || pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL midsend position: din=%h pkt_valid=%b want %h/1", din, pkt_valid, pl[5]);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (pkt_valid !== 1'b0 || din !== 8'd0 || pkt_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midsend async reset: pkt_valid=%b din=%h pkt_cnt=%0d err_cnt=%0d want 0/00/0/0",
               pkt_valid, din, pkt_cnt, err_cnt);
    end
    exp_pkt_cnt = 16'd0;
    exp_err_cnt = 16'd0;
    @(negedge clk);
    rstn = 1'b1;
    send_packet("after_reset", 2'd1, 2, rand_payload(2), 0, 0, -1, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy_stall();
    test_router_error();
    test_reject();
    test_max_len();
    test_random();
    test_reset_mid_send();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
